stg_ma: RTL and testbench
=========================

Name: stg_ma

Overview:
- Memory-access pipeline stage that consumes the execute stage's latched outputs (pc, instr, opc, targets, addr, result).
- Performs loads and stores over a req/ack data-memory port, stalling upstream until each access completes.
- Forwards all other instructions to writeback with one cycle of latency.
- Enforces a bounded wait on memory, with a sticky error flag if the bound is hit.

Parameters:
- MEM_TIMEOUT, 255: maximum BUSY cycles without ack before the access is aborted. Range 1..255; the counter is 8 bits.

Ports:
- iw_clk  in  1  clock, rising edge.
- iw_rst  in  1  reset, asynchronous, active-high.
- iw_pc  in  `SIZE_ADDR  pc from EX.
- iw_instr  in  `SIZE_DATA  instruction from EX.
- iw_opc  in  `SIZE_OPC  opcode from EX.
- iw_tgt_gp  in  `SIZE_TGT_GP  GP target index.
- iw_tgt_gp_we  in  1  GP write enable.
- iw_tgt_sr  in  `SIZE_TGT_SR  SR target index.
- iw_tgt_sr_we  in  1  SR write enable.
- iw_addr  in  `SIZE_ADDR  memory address computed in EX.
- iw_result  in  `SIZE_DATA  ALU result, or store data.
- iw_mem_ack  in  1  memory completes the current request.
- iw_mem_rdata  in  `SIZE_DATA  load data, valid with ack.
- or_mem_req  out  1  request held high until ack.
- or_mem_we  out  1  1 = store, 0 = load.
- or_mem_addr  out  `SIZE_ADDR  request address.
- or_mem_wdata  out  `SIZE_DATA  store data.
- or_mem_err  out  1  sticky timeout flag.
- ow_stall  out  1  freeze IF/ID/EX this cycle.
- ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr, ow_tgt_sr_we, ow_result  out  same widths as the matching inputs  registered outputs to writeback.

Behaviour:
- Reset: every output is 0 (or_mem_req, or_mem_err, ow_stall, all ow_* and all or_mem_*). State = IDLE, timeout counter = 0.
- Memory ops decoded from iw_opc:
  - Load: OPC_RU_LDu.
  - Store: OPC_RU_STu, OPC_IU_STiu, OPC_IS_STis.
  - All other opcodes are non-memory.
- States: IDLE and BUSY.
- IDLE, non-memory op:
  - Output latches capture the inputs at the next edge; ow_result = iw_result.
  - Latency 1 cycle, no stall.
- IDLE, memory op:
  - ow_stall = 1 combinationally.
  - At the next edge: register or_mem_req = 1, or_mem_we = is_store, or_mem_addr = iw_addr, or_mem_wdata = iw_result. State goes to BUSY, counter cleared.
  - Output latches load a bubble: tgt_gp_we = 0, tgt_sr_we = 0, opc = 0.
- BUSY:
  - ow_stall = ~iw_mem_ack.
  - Request fields stay constant while req = 1.
  - Inputs are held stable by the upstream stall.
  - Counter increments each cycle without ack.
- BUSY with iw_mem_ack = 1, completing at that edge:
  - Output latches capture the inputs.
  - ow_result = iw_mem_rdata for a load, iw_result for a store.
  - ow_tgt_gp_we = iw_tgt_gp_we for a load, 0 for a store.
  - or_mem_req drops; state goes to IDLE.
  - Minimum memory-op latency: 2 cycles (ack in the first BUSY cycle).
- Back-to-back memory ops: ow_stall drops in the ack cycle, so the next memory op arrives in IDLE the following cycle. There is one idle req cycle between accesses; this is required.
- Timeout: BUSY, counter == MEM_TIMEOUT-1 and no ack.
  - Drop req; set or_mem_err = 1 (sticky until reset).
  - Complete the instruction with ow_result = 0 and both write enables 0.
  - Deassert ow_stall that cycle; go to IDLE.
- Ack in the same cycle as timeout: ack wins and or_mem_err is not set.
- iw_mem_ack while IDLE or while req = 0: ignored.
- Reset asserted mid-access: req drops immediately (asynchronous) and all state clears. No completion is produced.
- Width rules: addresses and data pass unmodified; no sign or zero extension in this stage.

Decomposition:
- Add the MA_IDLE/MA_BUSY state encodings to a new shared header ma.vh; 1-bit encoding.
- Memory-op decode uses the existing opcode macros. Put it in a shared function so the hazard unit can reuse it.
- No sub-module is needed; the timeout counter is inline.

Test Plan:
- ADDu result 0x000123, tgt_gp_we = 1 → next cycle ow_result = 0x000123, ow_tgt_gp_we = 1, ow_stall never asserted.
- LDu addr 0x000040, ack after 3 BUSY cycles with rdata 0xABCDEF:
  - req high exactly 3 cycles, addr 0x000040, we = 0.
  - ow_stall high 3 cycles (IDLE cycle plus 2 non-ack BUSY cycles).
  - Then ow_result = 0xABCDEF with we passthrough.
- STis addr 0x000010, data 0xFFFFFE, ack in the first BUSY cycle → or_mem_we = 1, wdata 0xFFFFFE, ow_tgt_gp_we = 0, total 2 cycles.
- MEM_TIMEOUT = 4, no ack → req drops after 4 BUSY cycles, or_mem_err = 1 and remains 1. A subsequent LDu with ack completes normally while err stays 1.
- Ack coincident with the timeout cycle → load completes with rdata, or_mem_err = 0.
- Reset pulsed during BUSY → or_mem_req = 0 in the same cycle, all outputs 0. After release, an ADDu flows normally.

Source files
------------

// File: rtl/stg_ma_pkg.sv
// Shared widths, opcodes, MA state encoding and the memory-op decode helpers
// used by the memory-access stage and the hazard unit.
package stg_ma_pkg;

  localparam int SIZE_ADDR   = 24;
  localparam int SIZE_DATA   = 24;
  localparam int SIZE_OPC    = 8;
  localparam int SIZE_TGT_GP = 4;
  localparam int SIZE_TGT_SR = 2;

  localparam logic [SIZE_OPC-1:0] OPC_NOP     = 8'h00;
  localparam logic [SIZE_OPC-1:0] OPC_RU_ADDu = 8'h01;
  localparam logic [SIZE_OPC-1:0] OPC_RU_LDu  = 8'h10;
  localparam logic [SIZE_OPC-1:0] OPC_RU_STu  = 8'h11;
  localparam logic [SIZE_OPC-1:0] OPC_IU_STiu = 8'h12;
  localparam logic [SIZE_OPC-1:0] OPC_IS_STis = 8'h13;

  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_BUSY = 1'b1
  } ma_state_e;

  function automatic logic is_load_op(input logic [SIZE_OPC-1:0] opc);
    return (opc == OPC_RU_LDu);
  endfunction

  function automatic logic is_store_op(input logic [SIZE_OPC-1:0] opc);
    return (opc == OPC_RU_STu) || (opc == OPC_IU_STiu) || (opc == OPC_IS_STis);
  endfunction

  function automatic logic is_mem_op(input logic [SIZE_OPC-1:0] opc);
    return is_load_op(opc) || is_store_op(opc);
  endfunction

endpackage

// File: rtl/stg_ma.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack port with a
// bounded wait, stalls upstream while busy, and forwards results to writeback.
module stg_ma
  import stg_ma_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic [SIZE_ADDR-1:0]   iw_pc,
  input  logic [SIZE_DATA-1:0]   iw_instr,
  input  logic [SIZE_OPC-1:0]    iw_opc,
  input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
  input  logic                   iw_tgt_gp_we,
  input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
  input  logic                   iw_tgt_sr_we,
  input  logic [SIZE_ADDR-1:0]   iw_addr,
  input  logic [SIZE_DATA-1:0]   iw_result,
  input  logic                   iw_mem_ack,
  input  logic [SIZE_DATA-1:0]   iw_mem_rdata,
  output logic                   or_mem_req,
  output logic                   or_mem_we,
  output logic [SIZE_ADDR-1:0]   or_mem_addr,
  output logic [SIZE_DATA-1:0]   or_mem_wdata,
  output logic                   or_mem_err,
  output logic                   ow_stall,
  output logic [SIZE_ADDR-1:0]   ow_pc,
  output logic [SIZE_DATA-1:0]   ow_instr,
  output logic [SIZE_OPC-1:0]    ow_opc,
  output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
  output logic                   ow_tgt_gp_we,
  output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
  output logic                   ow_tgt_sr_we,
  output logic [SIZE_DATA-1:0]   ow_result
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  ma_state_e  r_state;
  ma_state_e  w_state_nxt;
  logic [7:0] r_cnt;
  logic       w_stall;
  logic       w_is_mem;
  logic       w_is_load;
  logic       w_ack;
  logic       w_timeout;

  // Ack only counts while a request is outstanding; timeout loses to ack.
  always_comb begin
    w_is_mem  = is_mem_op(iw_opc);
    w_is_load = is_load_op(iw_opc);
    w_ack     = iw_mem_ack & or_mem_req;
    w_timeout = (r_state == MA_BUSY) & ~w_ack & (r_cnt == TMO_LAST);
  end

  // State register.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      r_state <= MA_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and upstream stall.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      MA_IDLE: begin
        if (w_is_mem) begin
          w_state_nxt = MA_BUSY;
          w_stall     = 1'b1;
        end else begin
          w_state_nxt = MA_IDLE;
          w_stall     = 1'b0;
        end
      end
      MA_BUSY: begin
        if (w_ack || w_timeout) begin
          w_state_nxt = MA_IDLE;
          w_stall     = 1'b0;
        end else begin
          w_state_nxt = MA_BUSY;
          w_stall     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = MA_IDLE;
        w_stall     = 1'b0;
      end
    endcase
  end

  assign ow_stall = w_stall & ~iw_rst;

  // Memory request, timeout counter, sticky error and writeback latches.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      or_mem_req   <= 1'b0;
      or_mem_we    <= 1'b0;
      or_mem_addr  <= {SIZE_ADDR{1'b0}};
      or_mem_wdata <= {SIZE_DATA{1'b0}};
      or_mem_err   <= 1'b0;
      r_cnt        <= 8'd0;
      ow_pc        <= {SIZE_ADDR{1'b0}};
      ow_instr     <= {SIZE_DATA{1'b0}};
      ow_opc       <= {SIZE_OPC{1'b0}};
      ow_tgt_gp    <= {SIZE_TGT_GP{1'b0}};
      ow_tgt_gp_we <= 1'b0;
      ow_tgt_sr    <= {SIZE_TGT_SR{1'b0}};
      ow_tgt_sr_we <= 1'b0;
      ow_result    <= {SIZE_DATA{1'b0}};
    end else begin
      case (r_state)
        MA_IDLE: begin
          ow_pc     <= iw_pc;
          ow_instr  <= iw_instr;
          ow_tgt_gp <= iw_tgt_gp;
          ow_tgt_sr <= iw_tgt_sr;
          ow_result <= iw_result;
          if (w_is_mem) begin
            // Writeback sees a bubble while the access is outstanding.
            or_mem_req   <= 1'b1;
            or_mem_we    <= is_store_op(iw_opc);
            or_mem_addr  <= iw_addr;
            or_mem_wdata <= iw_result;
            r_cnt        <= 8'd0;
            ow_opc       <= {SIZE_OPC{1'b0}};
            ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr_we <= 1'b0;
          end else begin
            ow_opc       <= iw_opc;
            ow_tgt_gp_we <= iw_tgt_gp_we;
            ow_tgt_sr_we <= iw_tgt_sr_we;
          end
        end
        MA_BUSY: begin
          if (w_ack) begin
            or_mem_req   <= 1'b0;
            ow_pc        <= iw_pc;
            ow_instr     <= iw_instr;
            ow_opc       <= iw_opc;
            ow_tgt_gp    <= iw_tgt_gp;
            ow_tgt_sr    <= iw_tgt_sr;
            ow_tgt_sr_we <= iw_tgt_sr_we;
            ow_result    <= w_is_load ? iw_mem_rdata : iw_result;
            ow_tgt_gp_we <= w_is_load ? iw_tgt_gp_we : 1'b0;
          end else if (w_timeout) begin
            or_mem_req   <= 1'b0;
            or_mem_err   <= 1'b1;
            ow_pc        <= iw_pc;
            ow_instr     <= iw_instr;
            ow_opc       <= iw_opc;
            ow_tgt_gp    <= iw_tgt_gp;
            ow_tgt_sr    <= iw_tgt_sr;
            ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr_we <= 1'b0;
            ow_result    <= {SIZE_DATA{1'b0}};
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          or_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stg_ma.sv
// Directed scoreboard bench for stg_ma with a short memory timeout.
module tb_stg_ma;
  import stg_ma_pkg::*;

  localparam int TMO = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [SIZE_ADDR-1:0]   pc = '0;
  logic [SIZE_DATA-1:0]   instr = '0;
  logic [SIZE_OPC-1:0]    opc = '0;
  logic [SIZE_TGT_GP-1:0] tgt_gp = '0;
  logic                   tgt_gp_we = 1'b0;
  logic [SIZE_TGT_SR-1:0] tgt_sr = '0;
  logic                   tgt_sr_we = 1'b0;
  logic [SIZE_ADDR-1:0]   addr = '0;
  logic [SIZE_DATA-1:0]   result = '0;
  logic                   mem_ack = 1'b0;
  logic [SIZE_DATA-1:0]   mem_rdata = '0;
  logic                   mem_req, mem_we, mem_err, stall;
  logic [SIZE_ADDR-1:0]   mem_addr, o_pc;
  logic [SIZE_DATA-1:0]   mem_wdata, o_instr, o_result;
  logic [SIZE_OPC-1:0]    o_opc;
  logic [SIZE_TGT_GP-1:0] o_tgt_gp;
  logic                   o_gp_we, o_sr_we;
  logic [SIZE_TGT_SR-1:0] o_tgt_sr;

  typedef struct {
    logic [31:0] pc, instr, opc, tgt_gp, gp_we, tgt_sr, sr_we, res;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic exp_err = 1'b0;

  stg_ma #(.MEM_TIMEOUT(TMO)) dut (
    .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
    .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(tgt_gp_we), .iw_tgt_sr(tgt_sr),
    .iw_tgt_sr_we(tgt_sr_we), .iw_addr(addr), .iw_result(result),
    .iw_mem_ack(mem_ack), .iw_mem_rdata(mem_rdata), .or_mem_req(mem_req),
    .or_mem_we(mem_we), .or_mem_addr(mem_addr), .or_mem_wdata(mem_wdata),
    .or_mem_err(mem_err), .ow_stall(stall), .ow_pc(o_pc), .ow_instr(o_instr),
    .ow_opc(o_opc), .ow_tgt_gp(o_tgt_gp), .ow_tgt_gp_we(o_gp_we),
    .ow_tgt_sr(o_tgt_sr), .ow_tgt_sr_we(o_sr_we), .ow_result(o_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},    32'(mem_req), 32'd0);
    check({tag, "_stall"},  32'(stall), 32'd0);
    check({tag, "_err"},    32'(mem_err), 32'd0);
    check({tag, "_maddr"},  32'(mem_addr), 32'd0);
    check({tag, "_mwdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_pc"},     32'(o_pc), 32'd0);
    check({tag, "_opc"},    32'(o_opc), 32'd0);
    check({tag, "_gpwe"},   32'(o_gp_we), 32'd0);
    check({tag, "_srwe"},   32'(o_sr_we), 32'd0);
    check({tag, "_res"},    32'(o_result), 32'd0);
  endtask

  // Drives one instruction at a negedge and follows it to completion.
  // ack_at: index of the BUSY cycle that receives ack, or -1 for never.
  task automatic run_op(input string tag, input logic [SIZE_OPC-1:0] op,
                        input logic [23:0] a_pc, input logic [23:0] a_addr,
                        input logic [23:0] a_res, input logic a_gp_we,
                        input logic a_sr_we, input int ack_at,
                        input logic [23:0] rdata, input int exp_stall,
                        input int exp_req);
    exp_t e;
    bit   is_ld, is_st, done;
    int   n_stall, n_req;
    logic st_smp;
    is_ld = (op == OPC_RU_LDu);
    is_st = (op == OPC_RU_STu) || (op == OPC_IU_STiu) || (op == OPC_IS_STis);
    pc = a_pc; opc = op; instr = {op, a_pc[15:0]}; addr = a_addr; result = a_res;
    tgt_gp = 4'h5; tgt_gp_we = a_gp_we; tgt_sr = 2'h2; tgt_sr_we = a_sr_we;
    mem_rdata = rdata; mem_ack = 1'b0;
    e.pc = 32'(a_pc); e.instr = 32'({op, a_pc[15:0]}); e.opc = 32'(op);
    e.tgt_gp = 32'h5; e.tgt_sr = 32'h2;
    if (!(is_ld || is_st)) begin
      e.res = 32'(a_res); e.gp_we = 32'(a_gp_we); e.sr_we = 32'(a_sr_we);
    end else if (ack_at < 0 || ack_at >= TMO) begin
      e.res = 32'd0; e.gp_we = 32'd0; e.sr_we = 32'd0; exp_err = 1'b1;
    end else if (is_ld) begin
      e.res = 32'(rdata); e.gp_we = 32'(a_gp_we); e.sr_we = 32'(a_sr_we);
    end else begin
      e.res = 32'(a_res); e.gp_we = 32'd0; e.sr_we = 32'(a_sr_we);
    end
    sb_q.push_back(e);
    n_stall = 0; n_req = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (mem_req) begin
        mem_ack = (n_req == ack_at);
        check({tag, "_maddr"}, 32'(mem_addr), 32'(a_addr));
        check({tag, "_mwe"}, 32'(mem_we), 32'(is_st));
        if (is_st) check({tag, "_mwdata"}, 32'(mem_wdata), 32'(a_res));
        n_req++;
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      st_smp = stall;
      if (st_smp) n_stall++;
      @(posedge clk);
      if (!st_smp) done = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    #1;
    e = sb_q.pop_front();
    check({tag, "_pc"},     32'(o_pc), e.pc);
    check({tag, "_instr"},  32'(o_instr), e.instr);
    check({tag, "_opc"},    32'(o_opc), e.opc);
    check({tag, "_tgtgp"},  32'(o_tgt_gp), e.tgt_gp);
    check({tag, "_gpwe"},   32'(o_gp_we), e.gp_we);
    check({tag, "_tgtsr"},  32'(o_tgt_sr), e.tgt_sr);
    check({tag, "_srwe"},   32'(o_sr_we), e.sr_we);
    check({tag, "_res"},    32'(o_result), e.res);
    check({tag, "_req"},    32'(mem_req), 32'd0);
    check({tag, "_err"},    32'(mem_err), 32'(exp_err));
    check({tag, "_nstall"}, 32'(n_stall), 32'(exp_stall));
    check({tag, "_nreq"},   32'(n_req), 32'(exp_req));
    @(negedge clk);
    mem_ack = 1'b0; opc = OPC_NOP; tgt_gp_we = 1'b0; tgt_sr_we = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);

    run_op("addu",  OPC_RU_ADDu, 24'h000100, 24'h000000, 24'h000123, 1'b1, 1'b0, -1, 24'h0, 0, 0);
    run_op("ldu",   OPC_RU_LDu,  24'h000104, 24'h000040, 24'h000777, 1'b1, 1'b1, 2, 24'hABCDEF, 3, 3);
    run_op("stis",  OPC_IS_STis, 24'h000108, 24'h000010, 24'hFFFFFE, 1'b1, 1'b0, 0, 24'h000000, 1, 1);
    run_op("stu",   OPC_RU_STu,  24'h00010C, 24'h000020, 24'h00A5A5, 1'b1, 1'b1, 1, 24'h000000, 2, 2);
    run_op("ldcoin", OPC_RU_LDu, 24'h000110, 24'h000044, 24'h000001, 1'b1, 1'b0, TMO-1, 24'h123456, TMO, TMO);
    run_op("tmo",   OPC_IU_STiu, 24'h000114, 24'h000050, 24'h000099, 1'b1, 1'b1, -1, 24'h000000, TMO, TMO);
    run_op("ldaft", OPC_RU_LDu,  24'h000118, 24'h000060, 24'h000002, 1'b1, 1'b0, 1, 24'h0F0F0F, 2, 2);

    // Reset in the middle of an outstanding access.
    pc = 24'h000200; opc = OPC_RU_LDu; addr = 24'h000070; tgt_gp_we = 1'b1;
    mem_ack = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rstmid_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    exp_err = 1'b0;
    check_all_zero("rstmid");
    @(negedge clk);
    rst = 1'b0; opc = OPC_NOP; tgt_gp_we = 1'b0;
    @(negedge clk);
    run_op("addpost", OPC_RU_ADDu, 24'h000300, 24'h000000, 24'h00BEEF, 1'b1, 1'b1, -1, 24'h0, 0, 0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
